lab7_soc_pio_in_irq: RTL
========================

// Module: lab7_soc_pio_in_irq
// PURPOSE
//  Parametrised Avalon-MM slave input port for switch and button inputs, with a
//  synchronizer, optional per-bit debounce, an edge-capture register and a maskable
//  level IRQ. Sits between board inputs and the Nios II system interconnect.
//  Supersedes the fixed 8-bit, read-only, polled input port.
// PARAMETERS
//  WIDTH            8   number of input bits (1..32)
//  SYNC_STAGES      2   flip-flop synchronizer depth (>=2)
//  DEBOUNCE_CYCLES  0   consecutive stable cycles needed to accept a change; 0 = bypass
//  EDGE_MODE        0   0 = rising, 1 = falling, 2 = any edge sets edgecapture
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      reset, asynchronous, active-low
//  address     in   2      word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data; bits [WIDTH-1:0] used
//  readdata    out  32     registered read data; upper bits zero
//  in_port     in   WIDTH  asynchronous external inputs
//  irq         out  1      level interrupt request to the CPU
// BEHAVIOUR
//  Reset: all sync flops, stable, prev, debounce counters, irqmask, edgecapture,
//   readdata and irq are 0. No edge is detected on the first cycles after reset.
//  Sync: in_port passes through SYNC_STAGES flops, giving sync[WIDTH-1:0].
//  Debounce with DEBOUNCE_CYCLES=0: stable <= sync every cycle.
//  Debounce with DEBOUNCE_CYCLES>0, per bit:
//   - Counter width is clog2(DEBOUNCE_CYCLES+1).
//   - If sync==stable, the counter clears.
//   - Otherwise the counter increments. On the cycle where the counter is
//     DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync and the counter
//     clears. The counter never wraps.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
//  Edge detect: prev <= stable every cycle.
//   - rise = stable & ~prev; fall = ~stable & prev.
//   - edge = rise, fall or rise|fall, selected by EDGE_MODE.
//  Write: occurs when chipselect & ~write_n.
//   - Address 2: irqmask <= writedata[WIDTH-1:0].
//   - Address 3: write-1-to-clear of edgecapture bits.
//   - Addresses 0 and 1: writes are ignored.
//  Edgecapture: ec[i] <= (ec[i] & ~clr[i]) | edge[i].
//   - A new edge in the same cycle as a clear wins, so ec[i] stays 1.
//  IRQ: irq = |(edgecapture & irqmask), combinational from registers, no extra delay.
//   - Masking a pending bit drops irq the cycle after the write.
//   - Unmasking a pending bit raises irq the cycle after the write.
//  Read: readdata updates every clk edge, regardless of chipselect, from that
//   cycle's address. Read latency is 1 cycle.
//   - Address 0: stable. Address 1: 0. Address 2: irqmask. Address 3: edgecapture.
//   - A read of edgecapture returns the value before any same-cycle clear.
//  Latency (DEBOUNCE_CYCLES=0): an in_port change before edge k appears in stable
//   at edge k+SYNC_STAGES-1. It appears in readdata and edgecapture one edge later.
//   With debounce, add DEBOUNCE_CYCLES edges.
//  Reset mid-operation: everything returns to reset values immediately
//   (asynchronous). Pending edges are lost. No irq is generated by the
//   post-reset transition of stable from 0 to a high input unless edge mode
//   and mask permit: that is a genuine rising edge after reset.
// TESTING
//  1 Reset, WIDTH=8, in_port=8'hA5, read addr 0 after 4 clocks -> readdata=32'h000000A5;
//    during reset_n=0 -> readdata=0, irq=0.
//  2 EDGE_MODE=0, irqmask=8'h01, in_port bit0 0->1 -> ec=8'h01 and irq=1 at
//    SYNC_STAGES+1 edges after the change; write 32'h1 to addr 3 -> ec=0, irq=0 next cycle.
//  3 Edge on bit3 in the same cycle as a W1C of bit3 -> ec[3]=1 afterwards;
//    clearing bit2 alone leaves bit3 unchanged.
//  4 DEBOUNCE_CYCLES=4: 3-cycle high glitch on bit1 -> data unchanged, ec=0;
//    5-cycle high level -> data bit1=1 after 4 stable cycles, ec[1]=1.
//  5 EDGE_MODE=2, irqmask=0, toggle bit7 -> ec=8'h80, irq=0; write irqmask=8'h80
//    -> irq=1 next cycle; assert reset_n=0 mid-stream -> ec=0, irq=0 immediately.
//  6 Writes to addr 0 and 1 with 32'hFFFFFFFF -> no register changes;
//    read addr 1 -> 0; upper readdata bits always 0.

Source files
------------

// File: rtl/lab7_soc_pio_in_irq.sv
// Avalon-MM input port for board switches/buttons: synchronizer, optional
// per-bit debounce, edge capture with write-1-to-clear, and a maskable level IRQ.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        0 data, 1 reserved (reads 0), 2 irqmask, 3 edgecapture
//   chipselect, write_n slave select and active-low write strobe
//   writedata[31:0]     write data, bits [WIDTH-1:0] used
//   readdata[31:0]      registered read data (1-cycle latency), upper bits zero
//   in_port[WIDTH-1:0]  asynchronous external inputs
//   irq                 level interrupt, |(edgecapture & irqmask)
module lab7_soc_pio_in_irq #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned DATA_W = 32;

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  sync;
    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]  ec_q, ec_d;
    logic [WIDTH-1:0]  edge_det;
    logic [WIDTH-1:0]  clr;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              wr_en;
    logic              unused_wd;

    // Only the low WIDTH bits of writedata are architecturally meaningful.
    assign unused_wd = ^writedata;

    // Multi-flop synchronizer for the asynchronous inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            // Without debounce the last synchronizer flop is the stable register,
            // so a change reaches stable SYNC_STAGES-1 edges after it is sampled.
            assign stable = sync;
        end else begin : g_debounce
            localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [CNT_W-1:0] cnt_d [WIDTH];
            logic [WIDTH-1:0] stable_q, stable_d;

            // Per-bit counter of consecutive cycles sync has differed from stable.
            always_comb begin
                stable_d = stable_q;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    cnt_d[i] = cnt_q[i];
                    if (sync[i] == stable_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        stable_d[i] = sync[i];
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_q <= '0;
                    for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
                end else begin
                    stable_q <= stable_d;
                    for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
                end
            end

            assign stable = stable_q;
        end
    endgenerate

    // Edge selection, bus decode and register next-state.
    always_comb begin
        edge_det = '0;
        case (EDGE_MODE)
            0:       edge_det = stable & ~prev_q;
            1:       edge_det = ~stable & prev_q;
            default: edge_det = stable ^ prev_q;
        endcase

        wr_en     = chipselect & ~write_n;
        clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
        // A fresh edge overrides a same-cycle clear.
        ec_d      = (ec_q & ~clr) | edge_det;

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = DATA_W'(stable);
            2'd2:    readdata_d = DATA_W'(irqmask_q);
            2'd3:    readdata_d = DATA_W'(ec_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            ec_q       <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= stable;
            irqmask_q  <= irqmask_d;
            ec_q       <= ec_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // Combinational from registers so mask changes take effect right after the write.
    assign irq      = |(ec_q & irqmask_q);

endmodule
